// File: rtl/occupancy_grid_updater.sv
// ---------------------------------------------------------------------------
// occupancy_grid_updater
//
// Purpose:
//   Read-modify-write engine for a log-odds occupancy grid held in an
//   external RAM with a combinational read port. Each accepted request reads
//   one cell and writes it back with a saturated hit increment or miss
//   decrement, taking 3 cycles (IDLE -> READ -> WRITE). A clear pulse
//   sweeps the whole grid to zero, writing one cell per cycle in row-major
//   order.
//
// Optional feature (compile-time macro):
//   GRID_BOUNDS_CHECK_EN - when defined, out-of-range requests are dropped
//                          and flagged on the sticky oob_error output. When
//                          undefined, coordinates wrap to the index width
//                          and oob_error is tied low.
//
// Ports:
//   clock            in   rising-edge clock
//   reset_n          in   asynchronous active-low reset
//   req_valid        in   update request present
//   req_ready        out  request accepted this cycle (IDLE, no clear_start)
//   req_x / req_y    in   cell column / row (COORD_W bits, unsigned)
//   req_hit          in   1 = add LOG_ODDS_HIT, 0 = subtract LOG_ODDS_MISS
//   clear_start      in   one-cycle pulse starting a whole-grid clear
//   busy             out  update or clear in progress
//   ram_write_enable out  RAM write strobe
//   ram_x / ram_y    out  RAM column / row address
//   ram_wdata        out  RAM write data (signed log-odds)
//   ram_rdata        in   RAM combinational read data for ram_x/ram_y
//   oob_error        out  sticky out-of-bounds flag
// ---------------------------------------------------------------------------

package ram_pkg;
    localparam int WIDTH     = 8;
    localparam int HEIGHT    = 8;
    localparam int WORD_SIZE = 8;
endpackage

module occupancy_grid_updater #(
    parameter int WIDTH         = ram_pkg::WIDTH,
    parameter int HEIGHT        = ram_pkg::HEIGHT,
    parameter int WORD_SIZE     = ram_pkg::WORD_SIZE,
    parameter int LOG_ODDS_HIT  = 7,
    parameter int LOG_ODDS_MISS = 3,
    parameter int COORD_W       = 16
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [COORD_W-1:0]        req_x,
    input  logic [COORD_W-1:0]        req_y,
    input  logic                      req_hit,
    input  logic                      clear_start,
    output logic                      busy,
    output logic                      ram_write_enable,
    output logic [$clog2(WIDTH)-1:0]  ram_x,
    output logic [$clog2(HEIGHT)-1:0] ram_y,
    output logic [WORD_SIZE-1:0]      ram_wdata,
    input  logic [WORD_SIZE-1:0]      ram_rdata,
    output logic                      oob_error
);

    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    // Saturation limits and increments in the one-bit-wider sum domain.
    localparam logic signed [WORD_SIZE:0] SUM_MAX  = {2'b00, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [WORD_SIZE:0] SUM_MIN  = {2'b11, {(WORD_SIZE-1){1'b0}}};
    localparam logic signed [WORD_SIZE:0] HIT_INC  = (WORD_SIZE+1)'(LOG_ODDS_HIT);
    localparam logic signed [WORD_SIZE:0] MISS_DEC = (WORD_SIZE+1)'(LOG_ODDS_MISS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t state, state_next;

    // Request stage registers
    logic [X_W-1:0]       x_p0;
    logic [Y_W-1:0]       y_p0;
    logic                 hit_p0;

    // Read stage register
    logic [WORD_SIZE-1:0] rdata_p1;

    // Clear sweep position
    logic [X_W-1:0]       clr_x;
    logic [Y_W-1:0]       clr_y;
    logic                 clr_last;

    logic                 accept;
    logic                 req_oob;

    logic signed [WORD_SIZE:0] cell_ext;
    logic signed [WORD_SIZE:0] cell_sum;

    function automatic logic [WORD_SIZE-1:0] saturate(input logic signed [WORD_SIZE:0] v);
        if (v > SUM_MAX) begin
            return SUM_MAX[WORD_SIZE-1:0];
        end else if (v < SUM_MIN) begin
            return SUM_MIN[WORD_SIZE-1:0];
        end else begin
            return v[WORD_SIZE-1:0];
        end
    endfunction

    assign accept   = req_valid && req_ready;
    assign clr_last = (clr_x == X_LAST) && (clr_y == Y_LAST);

`ifdef GRID_BOUNDS_CHECK_EN
    localparam logic [COORD_W-1:0] WIDTH_C  = COORD_W'(WIDTH);
    localparam logic [COORD_W-1:0] HEIGHT_C = COORD_W'(HEIGHT);

    logic oob_q;

    assign req_oob = (req_x >= WIDTH_C) || (req_y >= HEIGHT_C);

    // Sticky until reset; an out-of-range request never leaves IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oob_q <= 1'b0;
        end else if (accept && req_oob) begin
            oob_q <= 1'b1;
        end
    end

    assign oob_error = oob_q;
`else
    // Coordinates wrap: only the low index bits are used.
    logic unused_coord_hi;

    assign req_oob         = 1'b0;
    assign oob_error       = 1'b0;
    assign unused_coord_hi = ^{req_x[COORD_W-1:X_W], req_y[COORD_W-1:Y_W]};
`endif

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; clear_start wins over a same-cycle request.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLEAR;
                end else if (req_valid && !req_oob) begin
                    state_next = READ;
                end
            end
            READ:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            CLEAR:   state_next = clr_last ? IDLE : CLEAR;
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: capture request; stage p1: capture RAM read; clear sweep
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_p0     <= '0;
            y_p0     <= '0;
            hit_p0   <= 1'b0;
            rdata_p1 <= '0;
            clr_x    <= '0;
            clr_y    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        clr_x <= '0;
                        clr_y <= '0;
                    end else if (accept && !req_oob) begin
                        x_p0   <= req_x[X_W-1:0];
                        y_p0   <= req_y[Y_W-1:0];
                        hit_p0 <= req_hit;
                    end
                end
                READ: begin
                    rdata_p1 <= ram_rdata;
                end
                CLEAR: begin
                    // Row-major: column advances fastest.
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        clr_y <= clr_y + 1'b1;
                    end else begin
                        clr_x <= clr_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p2: saturated log-odds update of the sampled cell
    always_comb begin
        cell_ext = {rdata_p1[WORD_SIZE-1], rdata_p1};
        if (hit_p0) begin
            cell_sum = cell_ext + HIT_INC;
        end else begin
            cell_sum = cell_ext - MISS_DEC;
        end
    end

    // Output logic
    always_comb begin
        req_ready        = 1'b0;
        busy             = (state != IDLE);
        ram_write_enable = 1'b0;
        ram_x            = '0;
        ram_y            = '0;
        ram_wdata        = '0;
        case (state)
            IDLE: begin
                req_ready = !clear_start;
            end
            READ: begin
                ram_x = x_p0;
                ram_y = y_p0;
            end
            WRITE: begin
                ram_x            = x_p0;
                ram_y            = y_p0;
                ram_write_enable = 1'b1;
                ram_wdata        = saturate(cell_sum);
            end
            CLEAR: begin
                ram_x            = clr_x;
                ram_y            = clr_y;
                ram_write_enable = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// ---------------------------------------------------------------------------
// tb_occupancy_grid_updater
//
// Scoreboard bench for occupancy_grid_updater (8x8 grid, 8-bit cells,
// hit +7, miss -3). A behavioural RAM answers the DUT's reads; a separate
// grid model predicts each write (cell, value, cycle) and queues it; a
// monitor pops and compares on every write strobe.
// ---------------------------------------------------------------------------
module tb_occupancy_grid_updater;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int HIT  = 7;
    localparam int MISS = 3;

    typedef struct {
        int x;
        int y;
        int d;
        int cyc;
    } exp_t;

    logic        clock       = 1'b0;
    logic        reset_n     = 1'b0;
    logic        req_valid   = 1'b0;
    logic        req_hit     = 1'b0;
    logic        clear_start = 1'b0;
    logic [15:0] req_x       = '0;
    logic [15:0] req_y       = '0;
    logic        req_ready;
    logic        busy;
    logic        ram_write_enable;
    logic        oob_error;
    logic [2:0]  ram_x;
    logic [2:0]  ram_y;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    // Behavioural RAM with a preload port for the bench
    logic signed [7:0] mem [H][W];
    logic              pl_we = 1'b0;
    logic [2:0]        pl_x  = '0;
    logic [2:0]        pl_y  = '0;
    logic [7:0]        pl_d  = '0;

    // Reference grid and scoreboard
    int   refg [H][W];
    exp_t expq[$];
    exp_t mon_e;
    bit   exp_oob = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int busy_n = 0;

    occupancy_grid_updater dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_x            (req_x),
        .req_y            (req_y),
        .req_hit          (req_hit),
        .clear_start      (clear_start),
        .busy             (busy),
        .ram_write_enable (ram_write_enable),
        .ram_x            (ram_x),
        .ram_y            (ram_y),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .oob_error        (oob_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign ram_rdata = mem[ram_y][ram_x];

    always @(posedge clock) begin
        if (ram_write_enable) begin
            mem[ram_y][ram_x] <= ram_wdata;
        end else if (pl_we) begin
            mem[pl_y][pl_x] <= pl_d;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Monitor: every write strobe must match the head of the queue.
    always @(negedge clock) begin
        if (reset_n && ram_write_enable) begin
            if (expq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                check("wr_x", int'(ram_x), mon_e.x);
                check("wr_y", int'(ram_y), mon_e.y);
                check("wr_data", int'($signed(ram_wdata)), mon_e.d);
                check("wr_cycle", cyc, mon_e.cyc);
            end
        end
    end

    // Reference model for an accepted request in cycle acc.
    task automatic model_accept(input int x, input int y, input bit hit, input int acc);
        exp_t e;
        int   ex;
        int   ey;
`ifdef GRID_BOUNDS_CHECK_EN
        if (x >= W || y >= H) begin
            exp_oob = 1'b1;
            return;
        end
`endif
        ex = x % W;
        ey = y % H;
        refg[ey][ex] = sat8(refg[ey][ex] + (hit ? HIT : -MISS));
        e.x   = ex;
        e.y   = ey;
        e.d   = refg[ey][ex];
        e.cyc = acc + 2;
        expq.push_back(e);
    endtask

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic send_req(input int x, input int y, input bit hit, output int acc);
        bit got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_x     = 16'(x);
        req_y     = 16'(y);
        req_hit   = hit;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("req_accepted", int'(got), 1);
        acc = cyc;
        if (got) model_accept(x, y, hit, acc);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic preload(input int x, input int y, input int v);
        pl_we = 1'b1;
        pl_x  = 3'(x);
        pl_y  = 3'(y);
        pl_d  = 8'(v);
        refg[y][x] = v;
        @(posedge clock);
        #1;
        pl_we = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            if (!busy && expq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_in_time", int'(ok), 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int a1;
        int a2;
        int c;
        int nbad;
        exp_t e;

        // Random grid contents loaded while reset is held
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                preload(x, y, int'($urandom_range(0, 255)) - 128);
        preload(2, 3, 0);

        check("rst_we", int'(ram_write_enable), 0);
        check("rst_ram_x", int'(ram_x), 0);
        check("rst_ram_y", int'(ram_y), 0);
        check("rst_wdata", int'(ram_wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_oob", int'(oob_error), 0);

        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_after_reset", int'(req_ready), 1);
        @(posedge clock);
        #1;

        // Hit on a zero cell; clear_start during READ must be ignored
        send_req(2, 3, 1, acc);
        clear_start = 1'b1;
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        wait_idle();

        // Saturation at both ends
        preload(1, 1, 124);
        send_req(1, 1, 1, acc);
        wait_idle();
        preload(1, 1, -126);
        send_req(1, 1, 0, acc);
        wait_idle();

        // Back-to-back misses
        preload(5, 6, 0);
        send_req(5, 6, 0, a1);
        send_req(5, 6, 0, a2);
        check("b2b_accept_spacing", a2 - a1, 3);
        wait_idle();

        // Clear with a same-cycle request
        clear_start = 1'b1;
        req_valid   = 1'b1;
        req_x       = 16'd3;
        req_y       = 16'd3;
        req_hit     = 1'b1;
        @(negedge clock);
        check("ready_low_with_clear", int'(req_ready), 0);
        c = cyc;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                e.x   = x;
                e.y   = y;
                e.d   = 0;
                e.cyc = c + 1 + y * W + x;
                expq.push_back(e);
                refg[y][x] = 0;
            end
        @(posedge clock);
        #1;
        clear_start = 1'b0;
        fork
            send_req(3, 3, 1, acc);
            begin
                busy_n = 0;
                repeat (65) begin
                    @(negedge clock);
                    if (busy) busy_n++;
                end
            end
        join
        check("clear_busy_cycles", busy_n, 64);
        check("accept_after_clear", acc, c + 65);
        wait_idle();

        // Out-of-range request
        send_req(8, 0, 1, acc);
        check("oob_busy", int'(busy), int'(expq.size() != 0));
        wait_idle();
        check("oob_flag", int'(oob_error), int'(exp_oob));
        send_req(0, 1, 1, acc);
        wait_idle();
        check("oob_flag_held", int'(oob_error), int'(exp_oob));

        // Randomized traffic
        repeat (40) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            send_req(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                     1'($urandom_range(0, 1)), acc);
        end
        wait_idle();
        check("oob_flag_random", int'(oob_error), int'(exp_oob));

        // Reset asserted during WRITE of a hit at (4,4)
        req_valid = 1'b1;
        req_x     = 16'd4;
        req_y     = 16'd4;
        req_hit   = 1'b1;
        @(negedge clock);
        check("rstw_ready", int'(req_ready), 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        check("rstw_in_write", int'(ram_write_enable), 1);
        reset_n = 1'b0;
        #1;
        check("rstw_we", int'(ram_write_enable), 0);
        check("rstw_ram_x", int'(ram_x), 0);
        check("rstw_ram_y", int'(ram_y), 0);
        check("rstw_wdata", int'(ram_wdata), 0);
        check("rstw_busy", int'(busy), 0);
        check("rstw_oob", int'(oob_error), 0);
        exp_oob = 1'b0;
        @(posedge clock);
        #1;
        check("rstw_cell_unchanged", int'(mem[4][4]), refg[4][4]);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rstw_ready_after", int'(req_ready), 1);
        @(posedge clock);
        #1;
        send_req(4, 4, 1, acc);
        wait_idle();

        nbad = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (int'(mem[y][x]) != refg[y][x]) nbad++;
        check("grid_vs_model_cells_differing", nbad, 0);
        check("queue_empty_at_end", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/occupancy_grid_updater.md
OCCUPANCY_GRID_UPDATER -- requirements
Module: occupancy_grid_updater

Interface
REQ-001 The block SHALL have the parameter WIDTH, default ram_pkg::WIDTH, meaning the number of grid columns.
REQ-002 The block SHALL have the parameter HEIGHT, default ram_pkg::HEIGHT, meaning the number of grid rows.
REQ-003 The block SHALL have the parameter WORD_SIZE, default ram_pkg::WORD_SIZE, meaning the signed log-odds cell width.
REQ-004 The block SHALL have the parameter LOG_ODDS_HIT, default 7, meaning the positive increment applied on a hit.
REQ-005 The block SHALL have the parameter LOG_ODDS_MISS, default 3, meaning the magnitude subtracted on a miss.
REQ-006 The block SHALL have the parameter COORD_W, default 16, meaning the unsigned request coordinate width.
REQ-007 Port list, one line per port (name  direction  width  meaning):
- clock  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  an update request is presented.
- req_ready  out  1  the block accepts a request this cycle.
- req_x  in  COORD_W  cell column.
- req_y  in  COORD_W  cell row.
- req_hit  in  1  1 = hit (add LOG_ODDS_HIT), 0 = miss (subtract LOG_ODDS_MISS).
- clear_start  in  1  single-cycle pulse that starts a whole-grid clear.
- busy  out  1  an update or clear is in progress.
- ram_write_enable  out  1  RAM write strobe.
- ram_x  out  width_index_t  RAM column address.
- ram_y  out  height_index_t  RAM row address.
- ram_wdata  out  word_t  RAM write data.
- ram_rdata  in  word_t  RAM combinational read data for ram_x/ram_y.
- oob_error  out  1  sticky out-of-bounds flag (see Configuration).

Function
REQ-008 States SHALL be IDLE, READ, WRITE and CLEAR.
REQ-009 req_ready SHALL be 1 only in IDLE with clear_start low; a request is accepted when req_valid and req_ready are both 1.
REQ-010 On accept, the block SHALL register the coordinates and req_hit, and go IDLE->READ.
REQ-011 READ (one cycle) SHALL drive the registered address, sample ram_rdata into an internal register, and go to WRITE.
REQ-012 WRITE (one cycle) SHALL assert ram_write_enable with ram_wdata set to the sampled value plus LOG_ODDS_HIT, or minus LOG_ODDS_MISS, then go to IDLE.
REQ-013 The update SHALL be computed as signed arithmetic one bit wider than WORD_SIZE and saturate to [-(2^(WORD_SIZE-1)), 2^(WORD_SIZE-1)-1].
REQ-014 Request latency SHALL be 3 cycles from accept to the write edge; throughput SHALL be one request per 3 cycles.
REQ-015 clear_start in IDLE SHALL enter CLEAR, and SHALL take priority over a same-cycle req_valid, which is not accepted.
REQ-016 CLEAR SHALL write 0 to every cell, one per cycle, in row-major order from (0,0) to (WIDTH-1,HEIGHT-1), then return to IDLE after exactly WIDTH*HEIGHT write cycles.
REQ-017 clear_start SHALL be ignored outside IDLE.
REQ-018 busy SHALL equal (state != IDLE).
REQ-019 ram_write_enable SHALL be 0 in IDLE and READ.

Reset
REQ-020 Asserting reset_n low SHALL asynchronously force, at any point including mid-update or mid-clear, all of the following; the interrupted cell is not written: state IDLE, ram_write_enable 0, ram_x/ram_y/ram_wdata 0, busy 0, oob_error 0, internal registers 0.
REQ-021 After reset_n rises, req_ready SHALL be 1 on the first clock edge.

Configuration
REQ-022 With GRID_BOUNDS_CHECK_EN defined, an accepted request with req_x>=WIDTH or req_y>=HEIGHT SHALL be dropped with no RAM access, set oob_error (cleared only by reset), and keep the block in IDLE.
REQ-023 Without GRID_BOUNDS_CHECK_EN, coordinates SHALL be truncated to index width (wrap-around), and oob_error SHALL be tied to 0.

Verification (WIDTH=HEIGHT=8, WORD_SIZE=8, HIT=7, MISS=3)
REQ-024 Reset, then hit at (2,3) with RAM cell = 0 -> one ram_write_enable pulse, 3 cycles after accept, at (2,3) with data 7.
REQ-025 Cell (1,1) = 124, hit -> writes 127; cell = -126, miss -> writes -128 (saturation).
REQ-026 clear_start with req_valid in the same cycle -> request not accepted; 64 consecutive zero writes from (0,0) to (7,7); busy high for 64 cycles; then the request is accepted.
REQ-027 reset_n low during WRITE of a hit at (4,4) -> no write occurs, all outputs 0, req_ready 1 after release.
REQ-028 With GRID_BOUNDS_CHECK_EN, request at (8,0) -> no write, oob_error=1 and stays 1; without the macro -> write at (0,0).
REQ-029 Back-to-back req_valid of miss,miss at (5,6) starting at 0 -> writes -3 then -6, accepts spaced 3 cycles.
